// File: rtl/sr_window_gen_pkg.sv
// Shared types and constants for the super-resolution window generator and conv engine.
// Pixels are opaque bit vectors; the datapath currently carries IEEE-754 singles.
package sr_window_gen_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int K_DEF      = 3;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  // A STRIDE of 1 needs no phase state, but a zero-width vector is illegal.
  function automatic int phase_w(int stride);
    return (stride > 1) ? $clog2(stride) : 1;
  endfunction

endpackage

// File: rtl/sr_window_gen_if.sv
// Pixel-in / window-out bundle between the raster source and the conv engine.
// Handshake: there is no ready. A pixel is consumed on every clk edge with ren=1.
// win_valid and frame_done are single-cycle strobes that the sink must take on the cycle they appear.
interface sr_window_gen_if
  import sr_window_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = K_DEF
);
  logic                  ren;
  logic                  sof;
  logic [DATA_W-1:0]     pixel;
  logic [K*K*DATA_W-1:0] out;
  logic                  win_valid;
  logic                  frame_done;

  modport master (output ren, sof, pixel, input out, win_valid, frame_done);
  modport slave  (input ren, sof, pixel, output out, win_valid, frame_done);
endinterface

// File: rtl/sr_window_gen_line_buffer.sv
// One image row of delay: dout is the pixel pushed DEPTH enables ago.
// Contents are not reset; the window logic never flags a window that could expose stale data.
module sr_window_gen_line_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sr_window_gen.sv
// KxK sliding-window generator over a raster pixel stream with STRIDE alignment and frame tracking.
// The window registers drive out directly, so a window appears one edge after its bottom-right pixel.
module sr_window_gen
  import sr_window_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = K_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int STRIDE = 1
) (
  input  logic           clk,
  input  logic           reset_FSM,
  sr_window_gen_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = phase_w(STRIDE);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

  logic [CW-1:0]     col, col_eff, col_nxt;
  logic [RW-1:0]     row, row_eff, row_nxt;
  logic [PW-1:0]     ph_c, ph_c_nxt, ph_r, ph_r_nxt;
  logic              hit, last_px, col_wrap;
  logic              win_valid_q, frame_done_q;
  logic [DATA_W-1:0] win    [K][K];
  logic [DATA_W-1:0] lb_in  [K-1];
  logic [DATA_W-1:0] lb_out [K-1];

  // Line buffer i holds the row i+1 rows above the incoming one.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_in[i] = bus.pixel;
    end else begin : g_tail
      assign lb_in[i] = lb_out[i-1];
    end
    sr_window_gen_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb (
      .clk  (clk),
      .en   (bus.ren),
      .din  (lb_in[i]),
      .dout (lb_out[i])
    );
  end

  // sof relocates the current pixel to (0,0); phases only matter once col/row reach K-1,
  // where they are re-zeroed, so stale phase after a re-sync is harmless.
  always_comb begin
    col_eff  = bus.sof ? '0 : col;
    row_eff  = bus.sof ? '0 : row;
    col_wrap = (col_eff == COL_LAST);
    hit      = (col_eff >= COL_K1) && (row_eff >= ROW_K1) && (ph_c == '0) && (ph_r == '0);
    last_px  = col_wrap && (row_eff == ROW_LAST);
    col_nxt  = col_wrap ? '0 : col_eff + 1'b1;
    row_nxt  = row_eff;
    ph_r_nxt = ph_r;
    if (col_nxt == COL_K1)  ph_c_nxt = '0;
    else if (ph_c == PH_LAST) ph_c_nxt = '0;
    else                    ph_c_nxt = ph_c + 1'b1;
    if (col_wrap) begin
      row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      if (row_nxt == ROW_K1)    ph_r_nxt = '0;
      else if (ph_r == PH_LAST) ph_r_nxt = '0;
      else                      ph_r_nxt = ph_r + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_FSM) begin
    if (reset_FSM) begin
      col          <= '0;
      row          <= '0;
      ph_c         <= '0;
      ph_r         <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else begin
      win_valid_q  <= bus.ren && hit;
      frame_done_q <= bus.ren && last_px;
      if (bus.ren) begin
        col  <= col_nxt;
        row  <= row_nxt;
        ph_c <= ph_c_nxt;
        ph_r <= ph_r_nxt;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        for (int r = 0; r < K - 1; r++) win[r][K-1] <= lb_out[K-2-r];
        win[K-1][K-1] <= bus.pixel;
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_out_r
    for (genvar c = 0; c < K; c++) begin : g_out_c
      assign bus.out[(r*K+c)*DATA_W +: DATA_W] = win[r][c];
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sr_window_gen.sv
// Directed bench for sr_window_gen: K=3 on a 4x4 image, STRIDE=1 (dut_a) and STRIDE=2 (dut_b) fed the same stream.
module tb_sr_window_gen;

  localparam int DW = 32;
  localparam int K  = 3;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int WW = K * K * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_window_gen_if #(.DATA_W(DW), .K(K)) ifa ();
  sr_window_gen_if #(.DATA_W(DW), .K(K)) ifb ();

  sr_window_gen #(.DATA_W(DW), .K(K), .IMG_W(IW), .IMG_H(IH), .STRIDE(1)) dut_a (
    .clk(clk), .reset_FSM(rst), .bus(ifa));
  sr_window_gen #(.DATA_W(DW), .K(K), .IMG_W(IW), .IMG_H(IH), .STRIDE(2)) dut_b (
    .clk(clk), .reset_FSM(rst), .bus(ifb));

  int n_cmp = 0;
  int n_err = 0;

  logic [WW-1:0] exp_qa[$];
  logic [WW-1:0] exp_qb[$];
  logic [DW-1:0] br_qa[$];
  logic [DW-1:0] br_qb[$];
  logic [DW-1:0] fd_qa[$];
  logic [DW-1:0] fd_qb[$];

  logic          fired = 1'b0;
  logic [DW-1:0] last_pix = '0;
  logic [WW-1:0] first_win;
  logic [6*DW-1:0] hold_exp;

  function automatic logic [DW-1:0] pix(int n);
    return 32'h3f000000 + (DW'(n) << 20);
  endfunction

  // Window whose bottom-right pixel is frame index p of a frame starting at pixel number base.
  function automatic logic [WW-1:0] win_of(int base, int p);
    logic [WW-1:0] w;
    int r, c;
    r = p / IW;
    c = p % IW;
    w = '0;
    for (int rr = 0; rr < K; rr++)
      for (int cc = 0; cc < K; cc++)
        w[(rr*K+cc)*DW +: DW] = pix(base + (r-K+1+rr)*IW + (c-K+1+cc));
    return w;
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(int n, bit s);
    @(negedge clk);
    ifa.ren = 1'b1; ifa.sof = s; ifa.pixel = pix(n);
    ifb.ren = 1'b1; ifb.sof = s; ifb.pixel = pix(n);
  endtask

  task automatic idle(int cyc, bit s);
    repeat (cyc) begin
      @(negedge clk);
      ifa.ren = 1'b0; ifa.sof = s;
      ifb.ren = 1'b0; ifb.sof = s;
    end
  endtask

  task automatic frame(int base, bit s);
    for (int i = 0; i < IW * IH; i++) push(base + i, s && (i == 0));
  endtask

  task automatic exp_a(int base, int p);
    exp_qa.push_back(win_of(base, p));
    br_qa.push_back(pix(base + p));
  endtask

  task automatic exp_b(int base, int p);
    exp_qb.push_back(win_of(base, p));
    br_qb.push_back(pix(base + p));
  endtask

  task automatic exp_fd(int n);
    fd_qa.push_back(pix(n));
    fd_qb.push_back(pix(n));
  endtask

  // Full 4x4 frame: STRIDE=1 windows end at 10,11,14,15; STRIDE=2 only at 10.
  task automatic exp_frame(int base);
    exp_a(base, 10); exp_a(base, 11); exp_a(base, 14); exp_a(base, 15);
    exp_b(base, 10);
    exp_fd(base + 15);
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    fired    <= ifa.ren;
    last_pix <= ifa.pixel;
  end

  always @(negedge clk) begin
    if (ifa.win_valid) begin
      check("a_win_expected", WW'(exp_qa.size() != 0), WW'(1));
      if (exp_qa.size() != 0) begin
        check("a_win_timing", WW'({fired, last_pix}), WW'({1'b1, br_qa.pop_front()}));
        check("a_win_data", ifa.out, exp_qa.pop_front());
      end
    end
    if (ifb.win_valid) begin
      check("b_win_expected", WW'(exp_qb.size() != 0), WW'(1));
      if (exp_qb.size() != 0) begin
        check("b_win_timing", WW'({fired, last_pix}), WW'({1'b1, br_qb.pop_front()}));
        check("b_win_data", ifb.out, exp_qb.pop_front());
      end
    end
    if (ifa.frame_done) begin
      check("a_fd_expected", WW'(fd_qa.size() != 0), WW'(1));
      if (fd_qa.size() != 0)
        check("a_fd_timing", WW'({fired, last_pix}), WW'({1'b1, fd_qa.pop_front()}));
    end
    if (ifb.frame_done) begin
      check("b_fd_expected", WW'(fd_qb.size() != 0), WW'(1));
      if (fd_qb.size() != 0)
        check("b_fd_timing", WW'({fired, last_pix}), WW'({1'b1, fd_qb.pop_front()}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    ifa.ren = 1'b0; ifa.sof = 1'b0; ifa.pixel = '0;
    ifb.ren = 1'b0; ifb.sof = 1'b0; ifb.pixel = '0;
    first_win = {pix(10), pix(9), pix(8), pix(6), pix(5), pix(4), pix(2), pix(1), pix(0)};
    hold_exp  = {pix(7), pix(6), pix(5), pix(3), pix(2), pix(1)};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a_out", ifa.out, WW'(0));
    check("rst_a_wv",  WW'(ifa.win_valid), WW'(0));
    check("rst_a_fd",  WW'(ifa.frame_done), WW'(0));
    check("rst_b_out", ifb.out, WW'(0));
    check("rst_b_wv",  WW'(ifb.win_valid), WW'(0));
    check("rst_b_fd",  WW'(ifb.frame_done), WW'(0));
    rst = 1'b0;

    // S1: one frame back-to-back; first window written out by hand
    exp_qa.push_back(first_win); br_qa.push_back(pix(10));
    exp_a(0, 11); exp_a(0, 14); exp_a(0, 15);
    exp_qb.push_back(first_win); br_qb.push_back(pix(10));
    exp_fd(15);
    frame(0, 1'b0);
    idle(2, 1'b0);

    // S2: three idle cycles after pixel 7, with sof high but ren low (must be ignored)
    exp_frame(0);
    for (int i = 0; i < 8; i++) push(i, 1'b0);
    repeat (3) begin
      idle(1, 1'b1);
      check("s2_hold_rows", WW'(ifa.out[WW-1:3*DW]), WW'(hold_exp));
    end
    for (int i = 8; i < 16; i++) push(i, 1'b0);
    idle(2, 1'b0);

    // S3: two frames back-to-back without sof
    exp_frame(0);
    exp_frame(16);
    frame(0, 1'b0);
    frame(16, 1'b0);
    idle(2, 1'b0);

    // S4: abort after pixel 5 with sof, then a frame whose sof coincides with the natural wrap
    exp_frame(16);
    exp_frame(32);
    for (int i = 0; i < 6; i++) push(i, 1'b0);
    frame(16, 1'b1);
    frame(32, 1'b1);
    idle(2, 1'b0);

    // S5: asynchronous reset mid-cycle after pixel 9
    for (int i = 0; i < 10; i++) push(i, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    ifa.ren = 1'b0; ifb.ren = 1'b0;
    #1;
    check("arst_a_out", ifa.out, WW'(0));
    check("arst_a_wv",  WW'(ifa.win_valid), WW'(0));
    check("arst_a_fd",  WW'(ifa.frame_done), WW'(0));
    check("arst_b_out", ifb.out, WW'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_frame(0);
    frame(0, 1'b0);
    idle(4, 1'b0);

    check("a_win_left", WW'(exp_qa.size()), WW'(0));
    check("b_win_left", WW'(exp_qb.size()), WW'(0));
    check("a_fd_left",  WW'(fd_qa.size()), WW'(0));
    check("b_fd_left",  WW'(fd_qb.size()), WW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
